lcd_spi_receiver: RTL and testbench

- Receive side of the LCD serial link: decodes the CSX/DC/SCK/SDA write stream produced by the LCD SPI master into tagged command/data bytes and RGB565 pixels with window coordinates.
- Serves as the FPGA-side LCD model for loopback self-test and as a sniffer on the LCD pins; write-only, with no SDA drive-back.
- Tracks CASET (0x2A), RASET (0x2B) and RAMWR (0x2C) to generate pixel x/y and a frame_done pulse.

---
 rtl/lcd_spi_receiver.sv | 227 ++++++++++++++++++++++
 tb/tb_lcd_spi_receiver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_receiver.sv
// lcd_spi_receiver
// Write-only receiver for the LCD serial link (CSX/DC/SCK/SDA). Recovers
// tagged command/data bytes. Tracks the CASET/RASET/RAMWR commands to turn
// the RAMWR byte stream into RGB565 pixels with window coordinates and an
// end-of-window pulse. It never drives SDA, so it can sit on live LCD pins.
module lcd_spi_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int LCD_WIDTH   = 240,
  parameter int LCD_HEIGHT  = 320,
  parameter int COORD_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               LCD_CSX,
  input  logic               LCD_DC,
  input  logic               LCD_SCK,
  input  logic               LCD_SDA,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_is_cmd,
  output logic               pix_valid,
  output logic [15:0]        pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               frame_done,
  output logic               err_partial
);

  typedef enum logic [1:0] {
    ST_NONE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR
  } state_t;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(LCD_WIDTH - 1);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(LCD_HEIGHT - 1);

  // Synchroniser chains: index SYNC_STAGES-1 is the synced value.
  logic [SYNC_STAGES-1:0] csx_sync, dc_sync, sck_sync, sda_sync;
  logic                   csx_hist, sck_hist;
  logic                   csx_s, dc_s, sck_s, sda_s;
  logic                   sck_rise, csx_rise;

  // Byte assembly.
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       shift_en, byte_done, rx_cmd, partial_err;
  logic [7:0] assembled;

  // Command decode and window tracking.
  state_t             state, state_next;
  logic [2:0]         arg_cnt;
  logic [COORD_W-1:0] start_r, end_r, end_val;
  logic [COORD_W-1:0] xs, xe, ys, ye, x, y;
  logic [7:0]         pix_hi;
  logic               half;
  logic               last_pix;

  assign csx_s = csx_sync[SYNC_STAGES-1];
  assign dc_s  = dc_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_hist;
  assign csx_rise = csx_s & ~csx_hist;

  // A rise coinciding with CSX release still belongs to the selected
  // transfer, so an 8th bit landing there completes its byte.
  assign shift_en    = sck_rise & (~csx_s | csx_rise);
  assign byte_done   = shift_en & (bit_cnt == 3'd7);
  assign assembled   = {shift_reg, sda_s};
  assign rx_cmd      = ~dc_s;
  assign partial_err = csx_rise & ~byte_done & ((bit_cnt != 3'd0) | shift_en);

  assign end_val  = end_r | COORD_W'({8'h00, assembled});
  assign last_pix = (x == xe) && (y == ye);

  // Input synchronisers plus history flops for edge detection.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      csx_sync <= '1;
      dc_sync  <= '0;
      sck_sync <= '0;
      sda_sync <= '0;
      csx_hist <= 1'b1;
      sck_hist <= 1'b0;
    end else begin
      csx_sync <= {csx_sync[SYNC_STAGES-2:0], LCD_CSX};
      dc_sync  <= {dc_sync[SYNC_STAGES-2:0], LCD_DC};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], LCD_SCK};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], LCD_SDA};
      csx_hist <= csx_s;
      sck_hist <= sck_s;
    end
  end

  // Shift register and bit counter; CSX release discards a partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (shift_en) shift_reg <= assembled[6:0];
      if (csx_rise)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Decode state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_NONE;
    else     state <= state_next;
  end

  // Next decode state: only a command byte changes it.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch forms.
    state_next = state;
    if (byte_done && rx_cmd) begin
      case (assembled)
        CMD_CASET: state_next = ST_CASET;
        CMD_RASET: state_next = ST_RASET;
        CMD_RAMWR: state_next = ST_RAMWR;
        default:   state_next = ST_NONE;
      endcase
    end
  end

  // Byte port, window arguments, pixel assembly and coordinate stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      byte_is_cmd <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
      err_partial <= 1'b0;
      arg_cnt     <= '0;
      start_r     <= '0;
      end_r       <= '0;
      xs          <= '0;
      xe          <= XE_RST;
      ys          <= '0;
      ye          <= YE_RST;
      x           <= '0;
      y           <= '0;
      pix_hi      <= '0;
      half        <= 1'b0;
    end else begin
      byte_valid  <= byte_done;
      pix_valid   <= 1'b0;
      frame_done  <= 1'b0;
      err_partial <= partial_err | (byte_done & rx_cmd & half);

      if (byte_done) begin
        byte_data   <= assembled;
        byte_is_cmd <= rx_cmd;

        if (rx_cmd) begin
          arg_cnt <= '0;
          half    <= 1'b0;
          if (assembled == CMD_RAMWR) begin
            x <= xs;
            y <= ys;
          end
        end else begin
          case (state)
            ST_CASET, ST_RASET: begin
              if (arg_cnt != 3'd4) arg_cnt <= arg_cnt + 3'd1;
              case (arg_cnt)
                3'd0: start_r <= COORD_W'({assembled, 8'h00});
                3'd1: start_r <= start_r | COORD_W'({8'h00, assembled});
                3'd2: end_r   <= COORD_W'({assembled, 8'h00});
                3'd3: begin
                  if (start_r <= end_val) begin
                    if (state == ST_CASET) begin
                      xs <= start_r;
                      xe <= end_val;
                    end else begin
                      ys <= start_r;
                      ye <= end_val;
                    end
                  end
                end
                default: ;
              endcase
            end
            ST_RAMWR: begin
              if (!half) begin
                pix_hi <= assembled;
                half   <= 1'b1;
              end else begin
                half       <= 1'b0;
                pix_valid  <= 1'b1;
                pix_data   <= {pix_hi, assembled};
                pix_x      <= x;
                pix_y      <= y;
                frame_done <= last_pix;
                if (last_pix) begin
                  x <= xs;
                  y <= ys;
                end else if (x < xe) begin
                  x <= x + 1'b1;
                end else begin
                  x <= xs;
                  if (y < ye) y <= y + 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// tb_lcd_spi_receiver
// Directed bench: drives the LCD write stream bit by bit. A negedge monitor
// logs every byte/pixel/error pulse. The linear sequence then compares the
// logs against hand-computed expectations.
module tb_lcd_spi_receiver;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
    logic        fd;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LCD_CSX = 1'b1;
  logic        LCD_DC = 1'b0;
  logic        LCD_SCK = 1'b0;
  logic        LCD_SDA = 1'b0;
  logic        byte_valid, byte_is_cmd, pix_valid, frame_done, err_partial;
  logic [7:0]  byte_data;
  logic [15:0] pix_data;
  logic [8:0]  pix_x, pix_y;

  int tests = 0;
  int failed = 0;
  int err_cnt = 0;
  int stray_fd = 0;
  logic [8:0] byte_q[$];
  pix_t       pix_q[$];

  lcd_spi_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .LCD_CSX    (LCD_CSX),
    .LCD_DC     (LCD_DC),
    .LCD_SCK    (LCD_SCK),
    .LCD_SDA    (LCD_SDA),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_is_cmd(byte_is_cmd),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done),
    .err_partial(err_partial)
  );

  always #5 clk = ~clk;

  // Log output pulses away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) byte_q.push_back({byte_is_cmd, byte_data});
      if (pix_valid) pix_q.push_back({pix_x, pix_y, pix_data, frame_done});
      if (err_partial) err_cnt++;
      if (frame_done && !pix_valid) stray_fd++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    byte_q.delete();
    pix_q.delete();
    err_cnt = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      LCD_SDA = b[i];
      repeat (3) @(negedge clk);
      LCD_SCK = 1'b1;
      repeat (3) @(negedge clk);
      LCD_SCK = 1'b0;
    end
  endtask

  // One byte in its own CSX frame; is_data drives DC.
  task automatic send_byte(input logic [7:0] b, input logic is_data);
    @(negedge clk);
    LCD_DC  = is_data;
    LCD_CSX = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(b, 8);
    repeat (3) @(negedge clk);
    LCD_CSX = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  task automatic expect_byte(input string tag, input logic is_cmd, input logic [7:0] d);
    logic [8:0] e;
    check({tag, "_present"}, byte_q.size() > 0, 1);
    if (byte_q.size() > 0) begin
      e = byte_q.pop_front();
      check({tag, "_cmd"}, e[8], is_cmd);
      check({tag, "_data"}, e[7:0], d);
    end
  endtask

  task automatic expect_pix(input string tag, input int ex, input int ey,
                            input logic [15:0] d, input logic fd);
    pix_t p;
    check({tag, "_present"}, pix_q.size() > 0, 1);
    if (pix_q.size() > 0) begin
      p = pix_q.pop_front();
      check({tag, "_x"}, p.x, ex);
      check({tag, "_y"}, p.y, ey);
      check({tag, "_data"}, p.d, d);
      check({tag, "_fd"}, p.fd, fd);
    end
  endtask

  logic [15:0] t2_pix [8];
  int          t2_x   [8];
  int          t2_y   [8];

  initial begin
    t2_pix = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
               16'h0000, 16'h1234, 16'hABCD, 16'h5555};
    t2_x   = '{10, 11, 12, 13, 10, 11, 12, 13};
    t2_y   = '{5, 5, 5, 5, 6, 6, 6, 6};

    // Reset state.
    repeat (4) @(negedge clk);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_xy", {pix_x, pix_y}, 0);
    check("rst_err", err_partial, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    clear_logs();

    // Test 1: CASET 00 0A 00 0D, CSX toggled between bytes.
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h0D, 1'b1);
    check("t1_nbytes", byte_q.size(), 5);
    expect_byte("t1_b0", 1'b1, 8'h2A);
    expect_byte("t1_b1", 1'b0, 8'h00);
    expect_byte("t1_b2", 1'b0, 8'h0A);
    expect_byte("t1_b3", 1'b0, 8'h00);
    expect_byte("t1_b4", 1'b0, 8'h0D);
    check("t1_err", err_cnt, 0);
    clear_logs();

    // Test 2: RASET 00 05 00 06, RAMWR, eight pixels over the 4x2 window.
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h2C, 1'b0);
    for (int i = 0; i < 8; i++) send_pixel(t2_pix[i]);
    check("t2_npix", pix_q.size(), 8);
    for (int i = 0; i < 8; i++)
      expect_pix($sformatf("t2_p%0d", i), t2_x[i], t2_y[i], t2_pix[i], i == 7);
    check("t2_nbytes", byte_q.size(), 22);
    clear_logs();

    // Test 3: ninth pixel wraps back to the window origin.
    send_pixel(16'h8001);
    expect_pix("t3_p8", 10, 5, 16'h8001, 1'b0);
    check("t3_err", err_cnt, 0);
    clear_logs();

    // Test 4: CSX released after 5 bits, then a full byte.
    @(negedge clk);
    LCD_DC  = 1'b1;
    LCD_CSX = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8'hFF, 5);
    repeat (3) @(negedge clk);
    LCD_CSX = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_err", err_cnt, 1);
    check("t4_nobyte", byte_q.size(), 0);
    send_byte(8'hA5, 1'b0);
    expect_byte("t4_a5", 1'b1, 8'hA5);
    check("t4_err_after", err_cnt, 1);
    clear_logs();

    // Test 5: RAMWR with an odd data byte cut off by a command.
    send_byte(8'h2C, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h00, 1'b0);
    check("t5_err", err_cnt, 1);
    check("t5_nopix", pix_q.size(), 0);
    expect_byte("t5_b0", 1'b1, 8'h2C);
    expect_byte("t5_b1", 1'b0, 8'h12);
    expect_byte("t5_b2", 1'b1, 8'h00);
    clear_logs();
    send_byte(8'h34, 1'b1);
    expect_byte("t5_none_data", 1'b0, 8'h34);
    check("t5_none_nopix", pix_q.size(), 0);
    check("t5_none_err", err_cnt, 0);
    clear_logs();

    // Test 6: CASET with start > end leaves the window at 10..13.
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h2C, 1'b0);
    send_pixel(16'h1111);
    send_pixel(16'h2222);
    expect_pix("t6_p0", 10, 5, 16'h1111, 1'b0);
    expect_pix("t6_p1", 11, 5, 16'h2222, 1'b0);

    // Reset mid-pixel and mid-byte.
    send_byte(8'h77, 1'b1);
    @(negedge clk);
    LCD_CSX = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8'hC0, 3);
    rst = 1'b1;
    LCD_CSX = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_byte_valid", byte_valid, 0);
    check("t6_rst_byte_data", byte_data, 0);
    check("t6_rst_byte_is_cmd", byte_is_cmd, 0);
    check("t6_rst_pix_valid", pix_valid, 0);
    check("t6_rst_pix_data", pix_data, 0);
    check("t6_rst_pix_x", pix_x, 0);
    check("t6_rst_pix_y", pix_y, 0);
    check("t6_rst_frame_done", frame_done, 0);
    check("t6_rst_err", err_partial, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    clear_logs();
    send_byte(8'h2C, 1'b0);
    send_pixel(16'hAAAA);
    send_pixel(16'h5555);
    expect_pix("t6_post_p0", 0, 0, 16'hAAAA, 1'b0);
    expect_pix("t6_post_p1", 1, 0, 16'h5555, 1'b0);
    check("t6_post_err", err_cnt, 0);
    check("stray_frame_done", stray_fd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
